// File: rtl/hazard_encoder_stream.sv
// hazard_encoder_stream
//
// Folds a stream of hazard bounding boxes into per-frame row and column
// occupancy vectors. One beat carries one box. The beat with in_last closes the
// frame, and the result is then held until the consumer takes it.
//
// Parameters
//   COORD_W : coordinate width (unsigned)
//   ROWS    : grid rows, width of row_vec
//   COLS    : grid columns, width of col_vec
//   MAX_HAZ : maximum number of boxes counted per frame
//
// Ports
//   clk, rst_n                 : clock (rising edge) and synchronous active-low reset
//   in_valid / in_ready        : box beat handshake
//   in_top, in_left,
//   in_bottom, in_right        : inclusive box bounds
//   in_last                    : final beat of the frame
//   out_valid / out_ready      : frame result handshake
//   row_vec, col_vec           : rows / columns covered by counted boxes
//   haz_count                  : number of boxes counted in the frame
//   overflow                   : frame offered more than MAX_HAZ well-formed boxes
//   bad_box                    : frame contained a box with top>bottom or left>right
module hazard_encoder_stream #(
    parameter int unsigned COORD_W = 8,
    parameter int unsigned ROWS    = 8,
    parameter int unsigned COLS    = 32,
    parameter int unsigned MAX_HAZ = 16,
    localparam int unsigned CNT_W  = $clog2(MAX_HAZ + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [COORD_W-1:0] in_top,
    input  logic [COORD_W-1:0] in_left,
    input  logic [COORD_W-1:0] in_bottom,
    input  logic [COORD_W-1:0] in_right,
    input  logic               in_last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [ROWS-1:0]    row_vec,
    output logic [COLS-1:0]    col_vec,
    output logic [CNT_W-1:0]   haz_count,
    output logic               overflow,
    output logic               bad_box
);

    typedef enum logic [0:0] {StAcc, StOut} state_e;

    state_e state;

    logic            box_bad;
    logic            count_full;
    logic [ROWS-1:0] row_mask;
    logic [COLS-1:0] col_mask;

    // Coordinates are zero-extended to 32 bits so that a grid index can never
    // wrap against a narrow coordinate.
    logic [31:0] top_ext;
    logic [31:0] left_ext;
    logic [31:0] bottom_ext;
    logic [31:0] right_ext;

    always_comb begin
        top_ext    = 32'(in_top);
        left_ext   = 32'(in_left);
        bottom_ext = 32'(in_bottom);
        right_ext  = 32'(in_right);
    end

    always_comb begin
        box_bad    = (in_top > in_bottom) || (in_left > in_right);
        count_full = (haz_count == CNT_W'(MAX_HAZ));
    end

    // Range masks. Bounds past the grid edge select nothing beyond it, so an
    // off-grid start yields an empty mask on that axis.
    always_comb begin
        row_mask = '0;
        for (int unsigned r = 0; r < ROWS; r++) begin
            row_mask[r] = (r >= top_ext) && (r <= bottom_ext);
        end
    end

    always_comb begin
        col_mask = '0;
        for (int unsigned c = 0; c < COLS; c++) begin
            col_mask[c] = (c >= left_ext) && (c <= right_ext);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= StAcc;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            row_vec   <= '0;
            col_vec   <= '0;
            haz_count <= '0;
            overflow  <= 1'b0;
            bad_box   <= 1'b0;
        end else begin
            unique case (state)
                StAcc: begin
                    if (in_valid) begin
                        if (box_bad) begin
                            bad_box <= 1'b1;
                        end else if (count_full) begin
                            overflow <= 1'b1;
                        end else begin
                            row_vec   <= row_vec | row_mask;
                            col_vec   <= col_vec | col_mask;
                            haz_count <= haz_count + CNT_W'(1);
                        end
                        if (in_last) begin
                            state     <= StOut;
                            in_ready  <= 1'b0;
                            out_valid <= 1'b1;
                        end
                    end
                end
                StOut: begin
                    // Handing off the result also clears it; no beat is taken
                    // on this edge because in_ready is still low.
                    if (out_ready) begin
                        state     <= StAcc;
                        in_ready  <= 1'b1;
                        out_valid <= 1'b0;
                        row_vec   <= '0;
                        col_vec   <= '0;
                        haz_count <= '0;
                        overflow  <= 1'b0;
                        bad_box   <= 1'b0;
                    end
                end
                default: begin
                    state <= StAcc;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hazard_encoder_stream.sv
// Directed bench for hazard_encoder_stream with hand-computed expectations.
module tb_hazard_encoder_stream;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_top;
    logic [7:0]  in_left;
    logic [7:0]  in_bottom;
    logic [7:0]  in_right;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  row_vec;
    logic [31:0] col_vec;
    logic [4:0]  haz_count;
    logic        overflow;
    logic        bad_box;

    int n_cmp;
    int n_err;

    hazard_encoder_stream #(
        .COORD_W(8),
        .ROWS   (8),
        .COLS   (32),
        .MAX_HAZ(16)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_top   (in_top),
        .in_left  (in_left),
        .in_bottom(in_bottom),
        .in_right (in_right),
        .in_last  (in_last),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .row_vec  (row_vec),
        .col_vec  (col_vec),
        .haz_count(haz_count),
        .overflow (overflow),
        .bad_box  (bad_box)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Presents one beat and returns 1 time unit after the accepting edge.
    task automatic send_beat(input logic [7:0] t, input logic [7:0] l, input logic [7:0] b,
                             input logic [7:0] r, input logic last);
        int n;
        in_top    = t;
        in_left   = l;
        in_bottom = b;
        in_right  = r;
        in_last   = last;
        in_valid  = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 50) check_eq("beat_ready_timeout", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic check_result(input string tag, input logic [7:0] rv, input logic [31:0] cv,
                                input logic [4:0] cnt, input logic ov, input logic bb);
        check_eq({tag, "_out_valid"}, 32'(out_valid), 32'd1);
        check_eq({tag, "_in_ready"}, 32'(in_ready), 32'd0);
        check_eq({tag, "_row_vec"}, 32'(row_vec), 32'(rv));
        check_eq({tag, "_col_vec"}, col_vec, cv);
        check_eq({tag, "_haz_count"}, 32'(haz_count), 32'(cnt));
        check_eq({tag, "_overflow"}, 32'(overflow), 32'(ov));
        check_eq({tag, "_bad_box"}, 32'(bad_box), 32'(bb));
    endtask

    task automatic release_result(input string tag);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check_eq({tag, "_rel_out_valid"}, 32'(out_valid), 32'd0);
        check_eq({tag, "_rel_in_ready"}, 32'(in_ready), 32'd1);
        check_eq({tag, "_rel_row_vec"}, 32'(row_vec), 32'd0);
        check_eq({tag, "_rel_haz_count"}, 32'(haz_count), 32'd0);
    endtask

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_top    = '0;
        in_left   = '0;
        in_bottom = '0;
        in_right  = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_in_ready", 32'(in_ready), 32'd1);
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_row_vec", 32'(row_vec), 32'd0);
        check_eq("rst_col_vec", col_vec, 32'd0);
        check_eq("rst_haz_count", 32'(haz_count), 32'd0);
        check_eq("rst_flags", {30'd0, overflow, bad_box}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Two boxes; result visible right after the last beat's edge.
        send_beat(8'd0, 8'd0, 8'd1, 8'd2, 1'b0);
        check_eq("two_partial_out_valid", 32'(out_valid), 32'd0);
        check_eq("two_partial_row_vec", 32'(row_vec), 32'h03);
        send_beat(8'd6, 8'd20, 8'd7, 8'd25, 1'b1);
        check_result("two", 8'hC3, 32'h03F0_0007, 5'd2, 1'b0, 1'b0);
        release_result("two");

        // Box clipped at both grid edges.
        send_beat(8'd5, 8'd30, 8'd12, 8'd40, 1'b1);
        check_result("clip", 8'hE0, 32'hC000_0000, 5'd1, 1'b0, 1'b0);
        release_result("clip");

        // Malformed box is flagged but not counted.
        send_beat(8'd3, 8'd0, 8'd2, 8'd4, 1'b0);
        send_beat(8'd1, 8'd1, 8'd1, 8'd1, 1'b1);
        check_result("bad", 8'h02, 32'h0000_0002, 5'd1, 1'b0, 1'b1);
        release_result("bad");

        // 17 unit boxes: last one overflows; rows >= 8 count but set no row bit.
        for (int i = 0; i < 17; i++) begin
            send_beat(8'(i), 8'(i), 8'(i), 8'(i), (i == 16));
        end
        check_result("ovf", 8'hFF, 32'h0000_FFFF, 5'd16, 1'b1, 1'b0);

        // Stall in the result state with a beat offered; it must be ignored.
        in_top    = 8'd0;
        in_left   = 8'd0;
        in_bottom = 8'd7;
        in_right  = 8'd31;
        in_last   = 1'b1;
        in_valid  = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            check_eq("stall_in_ready", 32'(in_ready), 32'd0);
            check_eq("stall_row_vec", 32'(row_vec), 32'hFF);
            check_eq("stall_col_vec", col_vec, 32'h0000_FFFF);
            check_eq("stall_haz_count", 32'(haz_count), 32'd16);
            check_eq("stall_overflow", 32'(overflow), 32'd1);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        release_result("ovf");
        send_beat(8'd0, 8'd0, 8'd0, 8'd0, 1'b1);
        check_result("after_stall", 8'h01, 32'h0000_0001, 5'd1, 1'b0, 1'b0);
        release_result("after_stall");

        // Reset mid-frame discards the partial frame.
        send_beat(8'd2, 8'd2, 8'd3, 8'd3, 1'b0);
        send_beat(8'd4, 8'd4, 8'd5, 8'd5, 1'b0);
        check_eq("mid_partial_row_vec", 32'(row_vec), 32'h3C);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check_eq("mid_rst_in_ready", 32'(in_ready), 32'd1);
        check_eq("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("mid_rst_row_vec", 32'(row_vec), 32'd0);
        check_eq("mid_rst_col_vec", col_vec, 32'd0);
        check_eq("mid_rst_haz_count", 32'(haz_count), 32'd0);
        send_beat(8'd7, 8'd31, 8'd7, 8'd31, 1'b1);
        check_result("post_rst", 8'h80, 32'h8000_0000, 5'd1, 1'b0, 1'b0);
        release_result("post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/hazard_encoder_stream.md
HAZARD_ENCODER_STREAM -- requirements
Module: hazard_encoder_stream

Interface
REQ-001 SHALL have parameter COORD_W, default 8, coordinate width.
REQ-002 SHALL have parameter ROWS, default 8, grid rows (row_vec width).
REQ-003 SHALL have parameter COLS, default 32, grid columns (col_vec width).
REQ-004 SHALL have parameter MAX_HAZ, default 16, max hazards accepted per frame; CNT_W = clog2(MAX_HAZ+1).
REQ-005 SHALL have port clk  input  1  clock; all logic on rising edge.
REQ-006 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-007 SHALL have port in_valid  input  1  hazard beat valid.
REQ-008 SHALL have port in_ready  output  1  block can accept a beat.
REQ-009 SHALL have port in_top, in_left, in_bottom, in_right  input  COORD_W each  inclusive box bounds.
REQ-010 SHALL have port in_last  input  1  beat is final hazard of frame.
REQ-011 SHALL have port out_valid  output  1  frame result valid.
REQ-012 SHALL have port out_ready  input  1  consumer takes result.
REQ-013 SHALL have port row_vec  output  ROWS  bit r set if any counted hazard covers row r.
REQ-014 SHALL have port col_vec  output  COLS  bit c set if any counted hazard covers column c.
REQ-015 SHALL have port haz_count  output  CNT_W  hazards counted in frame.
REQ-016 SHALL have port overflow  output  1  frame presented more than MAX_HAZ valid boxes.
REQ-017 SHALL have port bad_box  output  1  frame contained a box with top>bottom or left>right.

Function
REQ-018 SHALL implement FSM states ACC and OUT; transfer occurs when valid and ready are both 1 on a rising edge.
REQ-019 In ACC, in_ready SHALL be 1 and out_valid 0; in OUT, in_ready SHALL be 0 and out_valid 1.
REQ-020 An accepted beat with valid box (top<=bottom, left<=right) and haz_count<MAX_HAZ SHALL OR rows top..min(bottom,ROWS-1) into row_vec and columns left..min(right,COLS-1) into col_vec, and increment haz_count, all in the same cycle.
REQ-021 A valid box with top>=ROWS or left>=COLS SHALL be counted but SHALL set no bits on the off-grid axis; the in-grid axis still updates.
REQ-022 An accepted beat with top>bottom or left>right SHALL set bad_box (sticky for frame), SHALL NOT be counted and SHALL set no bits.
REQ-023 An accepted valid box with haz_count==MAX_HAZ SHALL set overflow (sticky for frame) and be discarded.
REQ-024 An accepted beat with in_last=1 SHALL be processed per REQ-020..023 and move FSM to OUT; out_valid SHALL rise the next cycle (latency 1).
REQ-025 In OUT, row_vec, col_vec, haz_count, overflow, bad_box SHALL hold stable until out_ready=1.
REQ-026 In OUT with out_ready=1, FSM SHALL go to ACC and clear all five result outputs to 0 in the same edge; no beat accepted in that cycle.
REQ-027 In ACC, result outputs SHALL show running partial values; consumers SHALL only sample them when out_valid=1.
REQ-028 in_valid with in_ready=0 SHALL be ignored (no state change); the source holds the beat.
REQ-029 Coordinate comparisons SHALL be unsigned at COORD_W bits; no wrap-around.

Reset
REQ-030 With rst_n=0 at a rising edge, FSM SHALL enter ACC and row_vec, col_vec, haz_count, overflow, bad_box, out_valid SHALL become 0, in_ready 1.
REQ-031 Reset mid-frame or in OUT SHALL discard the frame entirely; no out_valid from it.

Verification
REQ-032 Beats (0,0,1,2) then (6,20,7,25,last) -> out_valid 1 cycle after 2nd beat; row_vec=8'hC3, col_vec=32'h03F00007, haz_count=2, overflow=0, bad_box=0.
REQ-033 Single beat (5,30,12,40,last) -> row_vec=8'hE0, col_vec=32'hC0000000, haz_count=1.
REQ-034 Beats (3,0,2,4) then (1,1,1,1,last) -> bad_box=1, haz_count=1, row_vec=8'h02, col_vec=32'h00000002.
REQ-035 17 valid beats (i,i,i,i), i=0..16, last on 17th -> haz_count=16, overflow=1, row_vec=8'hFF, col_vec=32'h0000FFFF.
REQ-036 out_ready held 0 for 5 cycles in OUT -> in_ready=0, outputs stable; next frame (0,0,0,0,last) after release -> row_vec=8'h01, col_vec=32'h1, haz_count=1.
REQ-037 rst_n=0 for 1 cycle after two non-last beats -> all outputs 0, in_ready=1; following frame unaffected by discarded beats.
